mfk_uart_rx: RTL and testbench

MFK_UART_RX -- requirements
Module: mfk_uart_rx

---
 rtl/mfk_rx_pkg.sv | 22 ++
 rtl/sync2ff.sv | 28 ++
 rtl/mfk_uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_mfk_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mfk_rx_pkg.sv
// Shared types and constants for the MFK UART receiver.
// The PARITY state exists only when MFK_RX_PARITY_EN is defined.
`timescale 1ns/1ps
package mfk_rx_pkg;

    localparam int         DEF_CLKS_PER_BIT = 434;
    localparam int         DEF_VALID_LEN    = 4;
    localparam logic [7:0] MFK_HDR          = 8'h42;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef MFK_RX_PARITY_EN
        ,
        PARITY
`endif
    } rx_state_t;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the
// value both flops take during reset.
`timescale 1ns/1ps
module sync2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/mfk_uart_rx.sv
// 8N1 UART receiver for the MFK link, LSB first, mid-bit sampling.
// Define MFK_RX_PARITY_EN to add an even-parity bit and the par_err output.
`timescale 1ns/1ps
module mfk_uart_rx
    import mfk_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int VALID_LEN    = DEF_VALID_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] from_mfk,
    output logic       rx_valid,
    output logic       frm_err
`ifdef MFK_RX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    localparam int          TW      = $clog2(CLKS_PER_BIT);
    localparam int          VW      = $clog2(VALID_LEN + 1);
    localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rxd_s;
    logic          rxd_prev_reg;
    rx_state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_reg;
    logic [VW-1:0] valid_cnt_reg;
    logic          frm_err_reg;
    logic          load;
    logic          frm_pulse;
    logic          at_mid;
`ifdef MFK_RX_PARITY_EN
    logic          par_bad_reg, par_bad_next;
    logic          par_err_reg;
    logic          par_pulse;
`endif

    sync2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign at_mid = (timer_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            rxd_prev_reg <= rxd_s;
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = at_mid ? '0 : timer_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        load         = 1'b0;
        frm_pulse    = 1'b0;
`ifdef MFK_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        par_pulse    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                timer_next   = '0;
                bit_cnt_next = '0;
                if (rxd_prev_reg && !rxd_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Half-bit check rejects short glitches on the line.
                if (timer_reg == HALF_M1) begin
                    timer_next = '0;
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_mid) begin
                    shift_next   = {rxd_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef MFK_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef MFK_RX_PARITY_EN
            PARITY: begin
                if (at_mid) begin
                    par_bad_next = rxd_s ^ (^shift_reg);
                    par_pulse    = rxd_s ^ (^shift_reg);
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (at_mid) begin
                    if (rxd_s) begin
`ifdef MFK_RX_PARITY_EN
                        load = !par_bad_reg;
`else
                        load = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        frm_pulse  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Any low sample restarts the full-bit high-time requirement.
                if (!rxd_s) begin
                    timer_next = '0;
                end else if (at_mid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg      <= 8'h00;
            valid_cnt_reg <= '0;
            frm_err_reg   <= 1'b0;
        end else begin
            frm_err_reg <= frm_pulse;
            if (load) begin
                data_reg      <= shift_reg;
                valid_cnt_reg <= VW'(VALID_LEN);
            end else if (valid_cnt_reg != '0) begin
                valid_cnt_reg <= valid_cnt_reg - 1'b1;
            end
        end
    end

`ifdef MFK_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_reg <= 1'b0;
            par_err_reg <= 1'b0;
        end else begin
            par_bad_reg <= par_bad_next;
            par_err_reg <= par_pulse;
        end
    end

    assign par_err = par_err_reg;
`endif

    assign from_mfk = data_reg;
    assign rx_valid = (valid_cnt_reg != '0);
    assign frm_err  = frm_err_reg;

endmodule

// File: tb/tb_mfk_uart_rx.sv
// Randomised self-checking bench for mfk_uart_rx at CLKS_PER_BIT=16, VALID_LEN=4.
// Define MFK_RX_PARITY_EN to also exercise the parity variant.
`timescale 1ns/1ps
module tb_mfk_uart_rx;
    import mfk_rx_pkg::*;

    localparam int CPB = 16;
    localparam int VL  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] from_mfk;
    logic       rx_valid;
    logic       frm_err;
`ifdef MFK_RX_PARITY_EN
    logic       par_err;
`endif

    mfk_uart_rx #(.CLKS_PER_BIT(CPB), .VALID_LEN(VL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .from_mfk (from_mfk),
        .rx_valid (rx_valid),
        .frm_err  (frm_err)
`ifdef MFK_RX_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected good bytes in order plus event tallies.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int exp_valid = 0, exp_frm = 0, exp_par = 0;
    int valid_pulses = 0, frm_pulses = 0, par_pulses = 0;

    logic       prev_valid = 1'b0;
    logic       prev_frm   = 1'b0;
    int         hi_len     = 0;
    logic [7:0] cur        = 8'h00;
`ifdef MFK_RX_PARITY_EN
    logic       prev_par   = 1'b0;
`endif

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_pulses++;
            hi_len = 1;
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("rx_byte", from_mfk, cur);
                $display("rx byte 0x%02h (expected 0x%02h)", from_mfk, cur);
            end
        end else if (rx_valid) begin
            hi_len++;
        end else if (prev_valid) begin
            check("valid_len", hi_len, VL);
            check("hold_after_valid", from_mfk, cur);
        end
        if (frm_err) begin
            frm_pulses++;
            check("frm_width", prev_frm, 0);
        end
`ifdef MFK_RX_PARITY_EN
        if (par_err) begin
            par_pulses++;
            check("par_width", prev_par, 0);
        end
        prev_par = par_err;
`endif
        prev_valid = rx_valid;
        prev_frm   = frm_err;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_val, input int stop_len,
                              input bit par_flip, input int gap);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(CPB);
        end
`ifdef MFK_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        idle(CPB);
`endif
        if (stop_val && !par_flip) begin
            exp_q.push_back(d);
            exp_valid++;
            last_good = d;
        end
        if (!stop_val) exp_frm++;
        if (par_flip)  exp_par++;
        rxd = stop_val;
        idle(stop_len);
        rxd = 1'b1;
        idle(gap);
    endtask

    int v0, f0;
    logic [7:0] rb;

    initial begin
        rxd   = 1'b1;
        rst_n = 1'b0;
        idle(3);
        check("rst_from_mfk", from_mfk, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frm_err",  frm_err,  0);
        rst_n = 1'b1;
        idle(20);

        // Single header byte.
        v0 = valid_pulses;
        send_frame(MFK_HDR, 1'b1, CPB, 1'b0, 40);
        check("hdr_pulses", valid_pulses - v0, 1);
        check("hdr_value", from_mfk, MFK_HDR);

        // Eight frames with no idle gap.
        v0 = valid_pulses; f0 = frm_pulses;
        for (int i = 0; i < 8; i++) begin
            send_frame((i == 0) ? MFK_HDR : 8'(i), 1'b1, CPB, 1'b0, 0);
        end
        idle(40);
        check("b2b_pulses", valid_pulses - v0, 8);
        check("b2b_frm", frm_pulses - f0, 0);

        // Short low glitch must be rejected.
        v0 = valid_pulses;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(40);
        check("glitch_pulses", valid_pulses - v0, 0);
        check("glitch_hold", from_mfk, last_good);

        // Bad stop bit, then a good byte after 16 idle cycles.
        v0 = valid_pulses; f0 = frm_pulses;
        send_frame(8'hA5, 1'b0, CPB, 1'b0, 16);
        check("frm_hold", from_mfk, last_good);
        send_frame(8'h3C, 1'b1, CPB, 1'b0, 40);
        check("frm_pulses", frm_pulses - f0, 1);
        check("frm_valid", valid_pulses - v0, 1);
        check("after_frm", from_mfk, 8'h3C);

        // Reset asserted in the middle of bit 4 of 0xFF.
        rxd = 1'b0;
        idle(CPB);
        rxd = 1'b1;
        idle(4 * CPB + CPB / 2);
        rst_n = 1'b0;
        idle(2);
        check("midrst_from_mfk", from_mfk, 8'h00);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_frm_err",  frm_err,  0);
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(20);
        send_frame(8'h55, 1'b1, CPB, 1'b0, 40);
        check("post_rst", from_mfk, 8'h55);

        // Random bytes, some with shortened stop bits so the next start edge
        // lands while rx_valid is still high.
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, ($urandom_range(0, 1) != 0) ? 10 : CPB, 1'b0,
                       int'($urandom_range(0, 20)));
        end
        idle(40);
        check("rand_last", from_mfk, last_good);

`ifdef MFK_RX_PARITY_EN
        v0 = valid_pulses;
        send_frame(8'h07, 1'b1, CPB, 1'b1, 40);
        check("par_bad_valid", valid_pulses - v0, 0);
        check("par_bad_hold", from_mfk, last_good);
        send_frame(8'h07, 1'b1, CPB, 1'b0, 40);
        check("par_good_valid", valid_pulses - v0, 1);
        check("par_pulses", par_pulses, exp_par);
`endif

        idle(60);
        check("queue_drained", exp_q.size(), 0);
        check("total_valid", valid_pulses, exp_valid);
        check("total_frm", frm_pulses, exp_frm);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
